sad_engine_param: RTL and testbench

Parametrised successor to the fixed 8-bit SAD engine. It reads multi-lane operand words from two synchronous operand SRAMs (A, B) and computes one difference metric per block of pixels. The metric is sum of absolute differences (SAD) or sum of squared differences (SSD), selected per run. Each block result is written to the result SRAM (C), with saturation tracking. The engine sits between the operand SRAMs and the result SRAM, under Go/Done control from the host or testbench.

---
 rtl/sad_pkg.sv | 26 ++
 rtl/sad_engine_param_if.sv | 28 ++
 rtl/sad_lane_reduce.sv | 35 +++
 rtl/sad_engine_param.sv | 141 ++++++++++++++
 tb/tb_sad_engine_param.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the parametrised SAD/SSD engine.
package sad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } sad_state_e;

  localparam logic MODE_SAD = 1'b0;
  localparam logic MODE_SSD = 1'b1;

  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_ACC_WIDTH = 32;

  // Ceiling log2, never below 1 so degenerate counters keep a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sad_engine_param_if.sv
// Operand (A/B) and result (C) SRAM port bundle of the SAD engine.
interface sad_engine_param_if #(
  parameter int A_WIDTH   = 13,
  parameter int C_WIDTH   = 7,
  parameter int DATA_W    = 32,
  parameter int ACC_WIDTH = 32
);
  logic [A_WIDTH-1:0]   A_Addr;
  logic [A_WIDTH-1:0]   B_Addr;
  logic [DATA_W-1:0]    A_Data;
  logic [DATA_W-1:0]    B_Data;
  logic                 I_RW;
  logic                 I_En;
  logic [C_WIDTH-1:0]   C_Addr;
  logic [ACC_WIDTH-1:0] C_Data;
  logic                 O_RW;
  logic                 O_En;

  modport master (
    output A_Addr, B_Addr, I_RW, I_En, C_Addr, C_Data, O_RW, O_En,
    input  A_Data, B_Data
  );

  modport slave (
    input  A_Addr, B_Addr, I_RW, I_En, C_Addr, C_Data, O_RW, O_En,
    output A_Data, B_Data
  );
endinterface

// File: rtl/sad_lane_reduce.sv
// Combinational per-lane |a-b| or (a-b)^2, summed over all lanes at full width.
module sad_lane_reduce
  import sad_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int LANES   = 4,
  parameter int SUM_W   = 2 * D_WIDTH + clog2(LANES) + 1
) (
  input  logic [LANES*D_WIDTH-1:0] a_i,
  input  logic [LANES*D_WIDTH-1:0] b_i,
  input  logic                     mode_i,
  output logic [SUM_W-1:0]         sum_o
);
  localparam int M_W = 2 * D_WIDTH;

  logic [M_W-1:0] metric [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [D_WIDTH-1:0] a_l;
    logic [D_WIDTH-1:0] b_l;
    logic [D_WIDTH-1:0] absd;
    assign a_l  = a_i[j*D_WIDTH +: D_WIDTH];
    assign b_l  = b_i[j*D_WIDTH +: D_WIDTH];
    assign absd = (a_l >= b_l) ? (a_l - b_l) : (b_l - a_l);
    // |a-b|^2 equals (a-b)^2 and keeps the multiplier unsigned.
    assign metric[j] = (mode_i == MODE_SSD) ? (M_W'(absd) * M_W'(absd)) : M_W'(absd);
  end

  always_comb begin
    sum_o = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_o = sum_o + SUM_W'(metric[j]);
    end
  end
endmodule

// File: rtl/sad_engine_param.sv
// Block SAD/SSD engine: streams R operand words per block, writes one saturated
// result per block; R+2 cycles per block, no backpressure (fixed-latency SRAMs).
module sad_engine_param
  import sad_pkg::*;
#(
  parameter int D_WIDTH    = DEF_D_WIDTH,
  parameter int LANES      = 4,
  parameter int BLK_PIXELS = 256,
  parameter int NUM_BLKS   = 128,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Go,
  input  logic                Mode,
  output logic                Busy,
  output logic                Done,
  output logic                Sat,
  sad_engine_param_if.master  mem
);
  localparam int R       = BLK_PIXELS / LANES;
  localparam int A_WIDTH = clog2(NUM_BLKS * R);
  localparam int C_WIDTH = clog2(NUM_BLKS);
  localparam int W_WIDTH = clog2(R);
  localparam int SUM_W   = 2 * D_WIDTH + clog2(LANES) + 1;
  localparam int EXT_W   = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  sad_state_e           state_q, state_d;
  logic [W_WIDTH-1:0]   word_q, word_d;
  logic [C_WIDTH-1:0]   blk_q, blk_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 mode_q, mode_d;
  logic                 sat_q, sat_d;
  logic                 vld_q;
  logic [SUM_W-1:0]     lane_sum;
  logic [EXT_W-1:0]     acc_ext;

  sad_lane_reduce #(
    .D_WIDTH (D_WIDTH),
    .LANES   (LANES),
    .SUM_W   (SUM_W)
  ) u_reduce (
    .a_i    (mem.A_Data),
    .b_i    (mem.B_Data),
    .mode_i (mode_q),
    .sum_o  (lane_sum)
  );

  assign acc_ext = EXT_W'(acc_q) + EXT_W'(lane_sum);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    blk_d   = blk_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    sat_d   = sat_q;

    // Read data lands one cycle after the address, tracked by vld_q.
    if (vld_q) begin
      if (|acc_ext[EXT_W-1:ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = acc_ext[ACC_WIDTH-1:0];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_d = S_READ;
          mode_d  = Mode;
          blk_d   = '0;
          word_d  = '0;
          addr_d  = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      S_READ: begin
        if (word_q == W_WIDTH'(R - 1)) begin
          state_d = S_DRAIN;
        end else begin
          word_d = word_q + W_WIDTH'(1);
          addr_d = addr_q + A_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (blk_q == C_WIDTH'(NUM_BLKS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          blk_d   = blk_q + C_WIDTH'(1);
          word_d  = '0;
          addr_d  = addr_q + A_WIDTH'(1);
          acc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      blk_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      mode_q  <= MODE_SAD;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      vld_q   <= (state_q == S_READ);
    end
  end

  assign mem.I_En   = (state_q == S_READ);
  assign mem.I_RW   = 1'b0;
  assign mem.A_Addr = addr_q;
  assign mem.B_Addr = addr_q;
  assign mem.O_En   = (state_q == S_WRITE);
  assign mem.O_RW   = (state_q == S_WRITE);
  assign mem.C_Addr = blk_q;
  assign mem.C_Data = acc_q;

  assign Busy = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign Done = (state_q == S_DONE);
  assign Sat  = sat_q;
endmodule

// File: tb/tb_sad_engine_param.sv
// Bench for sad_engine_param: default instance plus a 16-bit accumulator instance.
module tb_sad_engine_param;
  localparam int R     = 64;
  localparam int WORDS = 128 * R;
  localparam int NB1   = 128;
  localparam int NB2   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic go1, mode1, go2, mode2;
  logic busy1, done1, sat1, busy2, done2, sat2;

  always #5 clk = ~clk;

  sad_engine_param_if #(.A_WIDTH(13), .C_WIDTH(7), .DATA_W(32), .ACC_WIDTH(32)) if1 ();
  sad_engine_param_if #(.A_WIDTH(8),  .C_WIDTH(2), .DATA_W(32), .ACC_WIDTH(16)) if2 ();

  sad_engine_param dut1 (
    .Clk(clk), .Rst(rst_n), .Go(go1), .Mode(mode1),
    .Busy(busy1), .Done(done1), .Sat(sat1), .mem(if1.master)
  );

  sad_engine_param #(.ACC_WIDTH(16), .NUM_BLKS(NB2)) dut2 (
    .Clk(clk), .Rst(rst_n), .Go(go2), .Mode(mode2),
    .Busy(busy2), .Done(done2), .Sat(sat2), .mem(if2.master)
  );

  logic [31:0] mem_a [WORDS];
  logic [31:0] mem_b [WORDS];
  logic [31:0] c1 [NB1];
  logic [15:0] c2 [NB2];
  int wr_cnt1 = 0;
  int wr_cnt2 = 0;
  bit oen_in_rst = 0;

  always @(posedge clk) begin
    if (if1.I_En) begin
      if1.A_Data <= mem_a[if1.A_Addr];
      if1.B_Data <= mem_b[if1.B_Addr];
    end
    if (if1.O_En && if1.O_RW) begin
      c1[if1.C_Addr] <= if1.C_Data;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (if2.I_En) begin
      if2.A_Data <= mem_a[if2.A_Addr];
      if2.B_Data <= mem_b[if2.B_Addr];
    end
    if (if2.O_En && if2.O_RW) begin
      c2[if2.C_Addr] <= if2.C_Data;
      wr_cnt2 <= wr_cnt2 + 1;
    end
  end

  always @(rst_n or if1.O_En) begin
    if (rst_n === 1'b0 && if1.O_En === 1'b1) oen_in_rst = 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain per-pixel arithmetic over the block's pixels.
  function automatic longint unsigned ref_raw(input int b, input bit m);
    longint unsigned s = 0;
    for (int p = 0; p < 256; p++) begin
      int w = b * R + p / 4;
      int sh = 8 * (p % 4);
      int a = int'((mem_a[w] >> sh) & 32'hFF);
      int v = int'((mem_b[w] >> sh) & 32'hFF);
      int d = (a > v) ? a - v : v - a;
      s += m ? longint'(d * d) : longint'(d);
    end
    return s;
  endfunction

  task automatic cmp_all(input int sel, input bit m, input string tag);
    longint unsigned lim, v;
    bit sat_exp = 0;
    int nb = (sel == 1) ? NB1 : NB2;
    lim = (sel == 1) ? 64'hFFFF_FFFF : 64'hFFFF;
    for (int b = 0; b < nb; b++) begin
      v = ref_raw(b, m);
      if (v > lim) begin
        v = lim;
        sat_exp = 1;
      end
      check($sformatf("%s_c%0d[%0d]", tag, sel, b), (sel == 1) ? 64'(c1[b]) : 64'(c2[b]), v);
    end
    check({tag, "_sat"}, (sel == 1) ? 64'(sat1) : 64'(sat2), 64'(sat_exp));
  endtask

  task automatic start(input int sel, input bit m);
    @(negedge clk);
    if (sel == 1) begin go1 = 1; mode1 = m; end
    else begin go2 = 1; mode2 = m; end
    @(posedge clk);
    #1;
    go1 = 0;
    go2 = 0;
  endtask

  task automatic wait_done(input int sel, input int n0, input int exp_edges, input string tag);
    int n = n0;
    while (((sel == 1) ? done1 : done2) !== 1'b1 && n < exp_edges + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_edges));
  endtask

  task automatic fill_random(input bit equal);
    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = equal ? mem_a[i] : $urandom;
    end
  endtask

  initial begin
    int base, k, bad;
    rst_n = 0; go1 = 0; mode1 = 0; go2 = 0; mode2 = 0;
    fill_random(1);
    #1;
    check("rst_flags", 64'({busy1, done1, sat1, if1.I_En, if1.O_En, if1.O_RW, if1.I_RW}), 64'd0);
    check("rst_addr", 64'({if1.A_Addr, if1.C_Addr}), 64'd0);
    check("rst_cdata", 64'(if1.C_Data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Identical operands: every SAD result is zero.
    base = wr_cnt1;
    start(1, 0);
    wait_done(1, 0, NB1 * (R + 2), "eq");
    cmp_all(1, 0, "eq");
    check("eq_writes", 64'(wr_cnt1 - base), 64'(NB1));
    check("eq_busy", 64'(busy1), 64'd0);

    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = 32'hFFFF_FFFF;
      mem_b[i] = 32'h0;
    end
    start(1, 0);
    wait_done(1, 0, NB1 * (R + 2), "ff_sad");
    cmp_all(1, 0, "ff_sad");
    check("ff_sad_const", 64'(c1[0]), 64'h0000_FF00);

    start(1, 1);
    wait_done(1, 0, NB1 * (R + 2), "ff_ssd");
    cmp_all(1, 1, "ff_ssd");
    check("ff_ssd_const", 64'(c1[NB1-1]), 64'h00FE_0100);

    // 16-bit accumulator: SSD saturates, SAD fits and clears Sat.
    start(2, 1);
    wait_done(2, 0, NB2 * (R + 2), "acc16_ssd");
    cmp_all(2, 1, "acc16_ssd");
    check("acc16_ssd_const", 64'(c2[2]), 64'hFFFF);
    start(2, 0);
    wait_done(2, 0, NB2 * (R + 2), "acc16_sad");
    cmp_all(2, 0, "acc16_sad");
    check("acc16_sad_const", 64'(c2[1]), 64'hFF00);

    // Exactly 2^16-1 must not saturate; one more unit must.
    for (int i = 0; i < NB2 * R; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = {8'd1, 8'd5, 8'd22, 8'd255};
    start(2, 1);
    wait_done(2, 0, NB2 * (R + 2), "edge_ok");
    cmp_all(2, 1, "edge_ok");
    check("edge_ok_sat", 64'(sat2), 64'd0);
    mem_a[3*R]   = {8'd1, 8'd5, 8'd22, 8'd255};
    mem_a[3*R+1] = 32'd1;
    start(2, 1);
    wait_done(2, 0, NB2 * (R + 2), "edge_sat");
    cmp_all(2, 1, "edge_sat");
    check("edge_sat_flag", 64'(sat2), 64'd1);

    // Go held and Mode toggled during a run: latched SSD must stick.
    fill_random(0);
    base = wr_cnt1;
    start(1, 1);
    k = 0;
    repeat (1000) begin
      @(negedge clk);
      go1 = 1;
      mode1 = ~mode1;
      @(posedge clk);
      #1;
      k++;
    end
    go1 = 0;
    wait_done(1, k, NB1 * (R + 2), "gopulse");
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("gopulse_done_hold", 64'(bad), 64'd0);
    check("gopulse_writes", 64'(wr_cnt1 - base), 64'(NB1));
    cmp_all(1, 1, "gopulse");

    // Abort in block 5, then a full rerun on fresh data.
    base = wr_cnt1;
    start(1, 0);
    check("go_done_drop", 64'({done1, busy1}), 64'b01);
    k = 0;
    while (wr_cnt1 != base + 5 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    check("abort_in_blk5", 64'({if1.I_En, if1.C_Addr}), 64'({1'b1, 7'd5}));
    #1;
    rst_n = 0;
    #1;
    check("abort_flags", 64'({busy1, done1, sat1, if1.I_En, if1.O_En, if1.O_RW}), 64'd0);
    check("abort_addr", 64'({if1.A_Addr, if1.B_Addr, if1.C_Addr}), 64'd0);
    check("abort_cdata", 64'(if1.C_Data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    check("abort_writes", 64'(wr_cnt1 - base), 64'd5);
    check("abort_no_oen", 64'(oen_in_rst), 64'd0);
    fill_random(0);
    base = wr_cnt1;
    start(1, 0);
    wait_done(1, 0, NB1 * (R + 2), "rerun");
    cmp_all(1, 0, "rerun");
    check("rerun_writes", 64'(wr_cnt1 - base), 64'(NB1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
